// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed radix-2 Booth multiplier and restoring divider
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;
  state_t state, state_n;
  logic [WIDTH:0] acc, booth_sum, trial;
  logic [WIDTH-1:0] mplier, mcand, rem_sh, rem_next, quot_next, a_mag, b_mag;
  logic q1, sign_q, sign_r, last;
  logic [CW-1:0] cnt;
  always_comb begin
    last = cnt == CW'(1);
    state_n = state == IDLE ? (mult_start ? MULT : div_start ? (b == '0 ? FIN : DIV) : IDLE) :
              state == FIN ? IDLE : last ? FIN : state;
    booth_sum = {mplier[0], q1} == 2'b01 ? acc + {mcand[WIDTH-1], mcand} :
                {mplier[0], q1} == 2'b10 ? acc - {mcand[WIDTH-1], mcand} : acc;
    rem_sh = {acc[WIDTH-2:0], mplier[WIDTH-1]};
    trial = {1'b0, rem_sh} - {1'b0, mcand};
    rem_next = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
    quot_next = {mplier[WIDTH-2:0], ~trial[WIDTH]};
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {acc, mplier, mcand, q1, sign_q, sign_r, cnt} <= '0;
      {hi, lo, busy, done, div_zero} <= '0;
    end else begin
      busy <= state_n == MULT || state_n == DIV;
      done <= state_n == FIN;
      if (state == IDLE && mult_start) begin
        acc <= '0;
        mplier <= b;
        mcand <= a;
        q1 <= 1'b0;
        cnt <= CW'(WIDTH);
        div_zero <= 1'b0;
      end else if (state == IDLE && div_start) begin
        if (b == '0) div_zero <= 1'b1;
        else begin
          acc <= '0;
          mplier <= a_mag;
          mcand <= b_mag;
          sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
          sign_r <= a[WIDTH-1];
          cnt <= CW'(WIDTH);
          div_zero <= 1'b0;
        end
      end else if (state == MULT) begin
        acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mplier <= {booth_sum[0], mplier[WIDTH-1:1]};
        q1 <= mplier[0];
        cnt <= cnt - CW'(1);
        if (last) begin
          hi <= booth_sum[WIDTH:1];
          lo <= {booth_sum[0], mplier[WIDTH-1:1]};
        end
      end else if (state == DIV) begin
        acc <= {1'b0, rem_next};
        mplier <= quot_next;
        cnt <= cnt - CW'(1);
        if (last) begin
          hi <= sign_r ? -rem_next : rem_next;
          lo <= sign_q ? -quot_next : quot_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random mult/div checks against a longint arithmetic model
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 0, reset = 1, mult_start = 0, div_start = 0;
  logic [W-1:0] a = '0, b = '0, hi, lo;
  logic busy, done, div_zero;
  int n_vec = 0, n_err = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input bit is_div, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output bit ez);
    int sa, sb;
    longint p, q, r;
    sa = ta;
    sb = tb_v;
    ez = 0;
    eh = m_hi;
    el = m_lo;
    if (!is_div) begin
      p = longint'(sa) * longint'(sb);
      eh = p[63:32];
      el = p[31:0];
    end else if (tb_v == '0) ez = 1;
    else begin
      q = longint'(sa) / longint'(sb);
      r = longint'(sa) % longint'(sb);
      eh = r[31:0];
      el = q[31:0];
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic run_op(input string tag, input bit is_div, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [W-1:0] eh, el;
    bit ez;
    model(is_div, ta, tb_v, eh, el, ez);
    @(negedge clk);
    a = ta;
    b = tb_v;
    mult_start = !is_div;
    div_start = is_div;
    @(negedge clk);
    mult_start = 0;
    div_start = 0;
    chk({tag, "_busy"}, busy, !ez);
    wait_done(tag, ez ? 1 : W + 1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_dz"}, div_zero, ez);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int dcount;
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("rst_out", {hi, lo}, 64'd0);
    chk("rst_flags", {busy, done, div_zero}, 3'b000);
    reset = 0;
    @(negedge clk);
    run_op("m_mixed", 0, 32'd7, 32'hFFFFFFFD);
    run_op("m_minmin", 0, 32'h80000000, 32'h80000000);
    run_op("m_maxmin", 0, 32'h7FFFFFFF, 32'h80000000);
    run_op("d_negdvd", 1, 32'hFFFFFFF9, 32'd2);
    run_op("d_negdvs", 1, 32'd7, 32'hFFFFFFFE);
    run_op("d_pos", 1, 32'd100, 32'd7);
    run_op("d_zero", 1, 32'd5, 32'd0);
    run_op("m_clrdz", 0, 32'd2, 32'd3);
    run_op("d_wrap", 1, 32'h80000000, 32'hFFFFFFFF);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      run_op($sformatf("rnd%0d", i), $urandom_range(0, 1) == 1, ra, rb);
    end
    // start while busy is ignored: a div-by-zero request here would set div_zero
    @(negedge clk);
    a = 32'd3;
    b = 32'd4;
    mult_start = 1;
    @(negedge clk);
    mult_start = 0;
    repeat (4) @(negedge clk);
    b = 32'd0;
    div_start = 1;
    @(negedge clk);
    div_start = 0;
    b = 32'd4;
    wait_done("busy_ign", W + 1 - 5);
    chk("busy_ign_hi", hi, 32'd0);
    chk("busy_ign_lo", lo, 32'd12);
    chk("busy_ign_dz", div_zero, 0);
    @(negedge clk);
    a = 32'd5;
    b = 32'd9;
    mult_start = 1;
    @(negedge clk);
    mult_start = 0;
    repeat (9) @(negedge clk);
    reset = 1;
    #1;
    chk("abort_out", {hi, lo}, 64'd0);
    chk("abort_flags", {busy, done, div_zero}, 3'b000);
    @(negedge clk);
    reset = 0;
    m_hi = '0;
    m_lo = '0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_nodone", dcount, 0);
    @(negedge clk);
    a = 32'd6;
    b = 32'd3;
    mult_start = 1;
    div_start = 1;
    @(negedge clk);
    mult_start = 0;
    div_start = 0;
    wait_done("both", W + 1);
    chk("both_hi", hi, 32'd0);
    chk("both_lo", lo, 32'd18);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
